cym_meas_ctrl: RTL and testbench

// - clk_fx-domain sequencer for the equal-precision cymometer; issues one measurement window per run.
// - Drives the soft gate (length in clk_fx cycles) to the gate edge detectors and to the fs-domain gate resync.
// - Waits for the fs-domain "count latched" toggle, then presents the fx count with a valid/ready handshake.
// - Supports single-shot or continuous operation, plus abort and timeout.

---
 rtl/cym_pkg.sv | 16 +
 rtl/cym_tgl_sync.sv | 42 ++++
 rtl/cym_meas_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_cym_meas_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cym_pkg.sv
// Shared definitions for the cymometer clk_fx-domain blocks.
//   - CYM_CNT_W   : default width of gate length and fx count
//   - cym_state_e : measurement sequencer state encoding
package cym_pkg;

  localparam int unsigned CYM_CNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GATE    = 3'd1,
    ST_WAIT_FS = 3'd2,
    ST_REPORT  = 3'd3,
    ST_GAP     = 3'd4
  } cym_state_e;

endpackage

// File: rtl/cym_tgl_sync.sv
// Toggle synchronizer: brings a toggle from another clock domain into clk,
// and emits a one-cycle pulse for every level change seen.
//   clk     in  : destination clock
//   rst_n   in  : asynchronous active-low reset
//   tgl_in  in  : asynchronous toggle input
//   edge_p  out : high for one clk cycle per detected toggle
module cym_tgl_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic tgl_in,
  output logic edge_p
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q,  hist_d;

  // Next values of the synchronizer chain and history flop.
  always_comb begin
    sync1_d = tgl_in;
    sync2_d = sync1_q;
    // History always follows the synchronized level, so edges seen while
    // nobody is listening are consumed rather than held pending.
    hist_d  = sync2_q;
  end

  // Synchronizer and history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  assign edge_p = sync2_q ^ hist_q;

endmodule

// File: rtl/cym_meas_ctrl.sv
// clk_fx-domain measurement sequencer for the equal-precision cymometer.
// Runs one soft-gate window of gate_len clk_fx cycles, waits for the fs
// domain to report its count latched, then offers the fx count on a
// valid/ready handshake. Supports continuous mode, abort and timeout.
//   clk_fx, rst_n          : clock / async active-low reset
//   start, cont_mode       : run request / auto-restart after the gap
//   abort                  : kill the current run (no result)
//   gate_len               : gate length, latched at run start (0 -> 1)
//   fs_done_tgl            : fs-domain "count latched" toggle
//   gate, busy             : soft gate / sequencer not idle
//   fx_cnt, res_valid,
//   res_err, res_ready     : result handshake (res_err = timeout)
module cym_meas_ctrl
  import cym_pkg::*;
#(
  parameter int unsigned CNT_W   = CYM_CNT_W,
  parameter int unsigned GAP_CYC = 8,
  parameter int unsigned TMO_CYC = 1024
) (
  input  logic             clk_fx,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont_mode,
  input  logic             abort,
  input  logic [CNT_W-1:0] gate_len,
  input  logic             fs_done_tgl,
  output logic             gate,
  output logic             busy,
  output logic [CNT_W-1:0] fx_cnt,
  output logic             res_valid,
  output logic             res_err,
  input  logic             res_ready
);

  localparam int unsigned TMR_MAX = (TMO_CYC > GAP_CYC) ? TMO_CYC : GAP_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_GAP = TMR_W'(GAP_CYC);
  localparam logic [TMR_W-1:0] TMR_TMO = TMR_W'(TMO_CYC);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Saturating increment: the fx count never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  cym_state_e       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;       // shared timeout / gap down-counter
  logic             gate_q, gate_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic             res_err_q, res_err_d;
  logic [CNT_W-1:0] fx_cnt_q, fx_cnt_d;
  logic             fs_edge_s;
  logic [CNT_W-1:0] len_load_s;
  logic [CNT_W-1:0] fx_inc_s;

  cym_tgl_sync u_tgl_sync (
    .clk    (clk_fx),
    .rst_n  (rst_n),
    .tgl_in (fs_done_tgl),
    .edge_p (fs_edge_s)
  );

  // A zero-length request still produces a one-cycle gate.
  assign len_load_s = (gate_len == CNT_ZERO) ? CNT_ONE : gate_len;
  assign fx_inc_s   = sat_inc(fx_cnt_q);

  // State register and all datapath flops.
  always_ff @(posedge clk_fx or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= CNT_ZERO;
      tmr_q       <= {TMR_W{1'b0}};
      gate_q      <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      fx_cnt_q    <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      tmr_q       <= tmr_d;
      gate_q      <= gate_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      fx_cnt_q    <= fx_cnt_d;
    end
  end

  // Next-state logic, run-length latch and shared down-counter.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    tmr_d   = tmr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_GATE;
          len_d   = len_load_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GATE: begin
        if (abort) begin
          state_d = ST_GAP;
          tmr_d   = TMR_GAP;
        end else if (fx_inc_s == len_q) begin
          // This edge completes the L-th gate cycle.
          state_d = ST_WAIT_FS;
          tmr_d   = TMR_TMO;
        end else begin
          state_d = ST_GATE;
        end
      end
      ST_WAIT_FS: begin
        if (abort) begin
          state_d = ST_GAP;
          tmr_d   = TMR_GAP;
        end else if (fs_edge_s) begin
          state_d = ST_REPORT;
        end else if (tmr_q == TMR_ONE) begin
          state_d = ST_REPORT;
        end else begin
          tmr_d   = tmr_q - TMR_ONE;
        end
      end
      ST_REPORT: begin
        if (abort) begin
          state_d = ST_GAP;
          tmr_d   = TMR_GAP;
        end else if (res_valid_q && res_ready) begin
          state_d = ST_GAP;
          tmr_d   = TMR_GAP;
        end else begin
          state_d = ST_REPORT;
        end
      end
      ST_GAP: begin
        if (tmr_q == TMR_ONE) begin
          if (cont_mode) begin
            state_d = ST_GATE;
            len_d   = len_load_s;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          tmr_d   = tmr_q - TMR_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs, derived from the state being entered.
  always_comb begin
    gate_d      = (state_d == ST_GATE);
    busy_d      = (state_d != ST_IDLE);
    res_valid_d = (state_d == ST_REPORT);
    fx_cnt_d    = fx_cnt_q;
    res_err_d   = res_err_q;
    if ((state_d == ST_GATE) && (state_q != ST_GATE)) begin
      fx_cnt_d  = CNT_ZERO;
      res_err_d = 1'b0;
    end else if (state_q == ST_GATE) begin
      fx_cnt_d  = fx_inc_s;
    end else if ((state_q == ST_WAIT_FS) && (state_d == ST_REPORT)) begin
      // An fs edge in the timeout cycle still counts as a good result.
      res_err_d = ~fs_edge_s;
    end else begin
      fx_cnt_d  = fx_cnt_q;
    end
  end

  assign gate      = gate_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_err   = res_err_q;
  assign fx_cnt    = fx_cnt_q;

endmodule

// File: tb/tb_cym_meas_ctrl.sv
module tb_cym_meas_ctrl;

  logic        clk_fx = 1'b0;
  logic        rst_n;
  logic        start;
  logic        cont_mode;
  logic        abort;
  logic [31:0] gate_len;
  logic        fs_done_tgl;
  logic        gate;
  logic        busy;
  logic [31:0] fx_cnt;
  logic        res_valid;
  logic        res_err;
  logic        res_ready;

  int n_checks = 0;
  int n_errors = 0;

  cym_meas_ctrl #(.CNT_W(32), .GAP_CYC(8), .TMO_CYC(1024)) dut (
    .clk_fx      (clk_fx),
    .rst_n       (rst_n),
    .start       (start),
    .cont_mode   (cont_mode),
    .abort       (abort),
    .gate_len    (gate_len),
    .fs_done_tgl (fs_done_tgl),
    .gate        (gate),
    .busy        (busy),
    .fx_cnt      (fx_cnt),
    .res_valid   (res_valid),
    .res_err     (res_err),
    .res_ready   (res_ready)
  );

  always #5 clk_fx = ~clk_fx;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_fx);
    #1;
  endtask

  task automatic do_start(input logic [31:0] len);
    gate_len = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic meas_gate(output int n);
    n = 0;
    while (gate === 1'b1 && n < 5000) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < 3000) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      n++;
      tick();
    end
  endtask

  task automatic flip_after(input int k);
    repeat (k) tick();
    fs_done_tgl = ~fs_done_tgl;
  endtask

  task automatic ack();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; cont_mode = 1'b0; abort = 1'b0;
    gate_len = 32'd0; fs_done_tgl = 1'b0; res_ready = 1'b0;
    repeat (3) tick();
    chk("rst_gate", {31'd0, gate}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_err", {31'd0, res_err}, 32'd0);
    chk("rst_fx", fx_cnt, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic 100-cycle run; gate_len change mid-run must be ignored
    do_start(32'd100);
    chk("r1_gate_on", {31'd0, gate}, 32'd1);
    chk("r1_fx0", fx_cnt, 32'd0);
    chk("r1_busy", {31'd0, busy}, 32'd1);
    gate_len = 32'd3;
    meas_gate(n);
    chk("r1_gate_len", n, 32'd100);
    flip_after(20);
    wait_valid(n);
    chk("r1_edge_lat", n, 32'd3);
    chk("r1_fx", fx_cnt, 32'd100);
    chk("r1_err", {31'd0, res_err}, 32'd0);
    ack();
    chk("r1_valid_drop", {31'd0, res_valid}, 32'd0);
    chk("r1_gap_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("r1_gap_len", n, 32'd8);

    // Zero length behaves as one
    do_start(32'd0);
    meas_gate(n);
    chk("r0_gate_len", n, 32'd1);
    flip_after(3);
    wait_valid(n);
    chk("r0_edge_lat", n, 32'd3);
    chk("r0_fx", fx_cnt, 32'd1);
    ack();
    wait_idle(n);
    chk("r0_gap_len", n, 32'd8);

    // Timeout: no fs toggle
    do_start(32'd5);
    meas_gate(n);
    chk("tmo_gate_len", n, 32'd5);
    wait_valid(n);
    chk("tmo_lat", n, 32'd1024);
    chk("tmo_err", {31'd0, res_err}, 32'd1);
    chk("tmo_fx", fx_cnt, 32'd5);
    ack();
    wait_idle(n);
    chk("tmo_gap_len", n, 32'd8);

    // Backpressure: result held for 50 cycles
    do_start(32'd7);
    meas_gate(n);
    flip_after(2);
    wait_valid(n);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("stall_valid", {31'd0, res_valid}, 32'd1);
      chk("stall_fx", fx_cnt, 32'd7);
      chk("stall_err", {31'd0, res_err}, 32'd0);
    end
    ack();
    chk("stall_valid_drop", {31'd0, res_valid}, 32'd0);
    wait_idle(n);
    chk("stall_gap_len", n, 32'd8);

    // Abort in the 5th gate cycle
    do_start(32'd100);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_gate", {31'd0, gate}, 32'd0);
    chk("abort_valid", {31'd0, res_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    chk("abort_gap_len", n, 32'd8);
    chk("abort_no_valid", {31'd0, res_valid}, 32'd0);

    // Continuous mode: back-to-back runs separated by the gap
    cont_mode = 1'b1;
    do_start(32'd10);
    meas_gate(n);
    chk("cont1_gate_len", n, 32'd10);
    flip_after(5);
    wait_valid(n);
    chk("cont1_fx", fx_cnt, 32'd10);
    ack();
    n = 0;
    while (gate !== 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("cont_gap_len", n, 32'd8);
    meas_gate(n);
    chk("cont2_gate_len", n, 32'd10);
    flip_after(5);
    wait_valid(n);
    chk("cont2_fx", fx_cnt, 32'd10);
    chk("cont2_err", {31'd0, res_err}, 32'd0);
    cont_mode = 1'b0;
    ack();
    wait_idle(n);
    chk("cont_end_gap", n, 32'd8);

    // Asynchronous reset mid-gate, then a fresh run
    do_start(32'd100);
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gate", {31'd0, gate}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_valid", {31'd0, res_valid}, 32'd0);
    chk("arst_fx", fx_cnt, 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    do_start(32'd100);
    meas_gate(n);
    chk("arst_gate_len", n, 32'd100);
    flip_after(20);
    wait_valid(n);
    chk("arst_edge_lat", n, 32'd3);
    chk("arst_fx_run", fx_cnt, 32'd100);
    chk("arst_err_run", {31'd0, res_err}, 32'd0);
    ack();
    wait_idle(n);
    chk("arst_gap_len", n, 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
